// File: rtl/dnn_pkg.sv
// Shared definitions for the DNN accelerator blocks.
//   - Slave register word offsets for the dot-product accelerator.
//   - dot_state_t: job sequencer states for dot_accel.
//   - q16_mul: Q16.16 x Q16.16 multiply, returns product[47:16] (floors toward -inf).
package dnn_pkg;

  localparam logic [3:0] REG_START = 4'd0;
  localparam logic [3:0] REG_BIAS  = 4'd1;
  localparam logic [3:0] REG_WADDR = 4'd2;
  localparam logic [3:0] REG_AADDR = 4'd3;
  localparam logic [3:0] REG_LEN   = 4'd5;
  localparam logic [3:0] REG_RELU  = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_W,
    ST_WAIT_W,
    ST_RD_A,
    ST_WAIT_A,
    ST_MAC,
    ST_FINISH
  } dot_state_t;

  // The arithmetic shift of the full 64-bit product drops the 16 fraction
  // bits with floor semantics; the cast keeps bits [47:16].
  function automatic logic signed [31:0] q16_mul(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    return 32'(p >>> 16);
  endfunction

endpackage

// File: rtl/q16_mac.sv
// Registered Q16.16 multiply-accumulate.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clears the accumulator (wins over en)
//   en         : adds q16_mul(a, b) to the accumulator, 32-bit wrapping
//   a, b       : signed Q16.16 operands
//   acc        : signed Q16.16 running sum
module q16_mac
  import dnn_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  output logic signed [31:0] acc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + q16_mul(a, b);
    end
  end

endmodule

// File: rtl/dot_accel.sv
// Avalon-MM dot-product accelerator: one neuron (sum(w[i]*a[i]) + bias,
// optional ReLU) per start, operands fetched from memory one word at a time.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   slave_*              : CPU register port (zero-latency reads, stalls while busy)
//   master_*             : read-only memory port, one outstanding read at a time
module dot_accel
  import dnn_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              slave_waitrequest,
  input  logic [3:0]        slave_address,
  input  logic              slave_read,
  output logic [31:0]       slave_readdata,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  input  logic              master_waitrequest,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  input  logic [31:0]       master_readdata,
  input  logic              master_readdatavalid
);

  dot_state_t state, state_nxt;

  logic [31:0]        bias_r, w_addr_r, a_addr_r, len_r, result_r, idx_r;
  logic               relu_r;
  logic signed [31:0] w_op_p0, a_op_p0, acc_p1, sum;
  logic [31:0]        elem_off, idx_inc;
  logic               busy, cfg_wr, start, vld_p0;

  assign busy              = (state != ST_IDLE);
  assign slave_waitrequest = busy & (slave_read | slave_write);
  // Writes only land once the access is no longer stalled, i.e. in IDLE.
  assign cfg_wr            = slave_write & ~busy;
  assign start             = cfg_wr & (slave_address == REG_START);
  assign elem_off          = {idx_r[29:0], 2'b00};
  assign idx_inc           = idx_r + 32'd1;
  assign sum               = acc_p1 + $signed(bias_r);

  always_comb begin
    slave_readdata = '0;
    case (slave_address)
      REG_START: slave_readdata = result_r;
      REG_BIAS:  slave_readdata = bias_r;
      REG_WADDR: slave_readdata = w_addr_r;
      REG_AADDR: slave_readdata = a_addr_r;
      REG_LEN:   slave_readdata = len_r;
      REG_RELU:  slave_readdata = {31'd0, relu_r};
      default:   slave_readdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    master_read    = 1'b0;
    master_address = '0;
    vld_p0         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (len_r == 32'd0) ? ST_FINISH : ST_RD_W;
        end
      end
      ST_RD_W: begin
        master_read    = 1'b1;
        master_address = ADDR_W'(w_addr_r + elem_off);
        if (!master_waitrequest) begin
          state_nxt = ST_WAIT_W;
        end
      end
      ST_WAIT_W: begin
        if (master_readdatavalid) begin
          state_nxt = ST_RD_A;
        end
      end
      ST_RD_A: begin
        master_read    = 1'b1;
        master_address = ADDR_W'(a_addr_r + elem_off);
        if (!master_waitrequest) begin
          state_nxt = ST_WAIT_A;
        end
      end
      ST_WAIT_A: begin
        if (master_readdatavalid) begin
          state_nxt = ST_MAC;
        end
      end
      ST_MAC: begin
        vld_p0    = 1'b1;
        state_nxt = (idx_inc < len_r) ? ST_RD_W : ST_FINISH;
      end
      ST_FINISH: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_r   <= '0;
      w_addr_r <= '0;
      a_addr_r <= '0;
      len_r    <= '0;
      relu_r   <= 1'b0;
      result_r <= '0;
      idx_r    <= '0;
      w_op_p0  <= '0;
      a_op_p0  <= '0;
    end else begin
      if (cfg_wr) begin
        case (slave_address)
          REG_BIAS:  bias_r   <= slave_writedata;
          REG_WADDR: w_addr_r <= slave_writedata;
          REG_AADDR: a_addr_r <= slave_writedata;
          REG_LEN:   len_r    <= slave_writedata;
          REG_RELU:  relu_r   <= slave_writedata[0];
          default:   ;
        endcase
      end
      // Stage p0: operand capture, only in the matching wait state.
      if (state == ST_WAIT_W && master_readdatavalid) begin
        w_op_p0 <= master_readdata;
      end
      if (state == ST_WAIT_A && master_readdatavalid) begin
        a_op_p0 <= master_readdata;
      end
      if (start) begin
        idx_r <= '0;
      end else if (state == ST_MAC) begin
        idx_r <= idx_inc;
      end
      // Stage p1 -> result: bias add and optional ReLU on the final sum.
      if (state == ST_FINISH) begin
        result_r <= (relu_r && sum[31]) ? '0 : sum;
      end
    end
  end

  q16_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (vld_p0),
    .a     (w_op_p0),
    .b     (a_op_p0),
    .acc   (acc_p1)
  );

endmodule

// File: tb/tb_dot_accel.sv
`timescale 1ns/1ps
module tb_dot_accel;
  import dnn_pkg::*;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              slave_waitrequest;
  logic [3:0]        slave_address = '0;
  logic              slave_read = 1'b0;
  logic [31:0]       slave_readdata;
  logic              slave_write = 1'b0;
  logic [31:0]       slave_writedata = '0;
  logic              master_waitrequest = 1'b0;
  logic [ADDR_W-1:0] master_address;
  logic              master_read;
  logic [31:0]       master_readdata = '0;
  logic              master_readdatavalid = 1'b0;

  dot_accel #(.ADDR_W(ADDR_W)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Word-addressed memory: byte address bits [11:2] select the word.
  logic [31:0] mem [0:1023];
  localparam logic [31:0] WB = 32'h0000_0100;
  localparam logic [31:0] AB = 32'h0000_0800;

  // Memory responder: random waitrequest and extra latency per read.
  int wait_lo = 0, wait_hi = 0, lat_lo = 0, lat_hi = 0;
  bit in_req = 0, pending = 0;
  int wcnt = 0, lcnt = 0, extra = 0, reads = 0;
  logic [31:0] pdata = '0;
  logic [31:0] addr_q[$];

  always @(negedge clk) begin
    master_readdatavalid = 1'b0;
    master_readdata      = $urandom();
    if (pending) begin
      if (lcnt == 0) begin
        master_readdatavalid = 1'b1;
        master_readdata      = pdata;
        pending              = 0;
      end else begin
        lcnt--;
        extra++;
      end
    end
    if (!master_read) begin
      in_req             = 0;
      master_waitrequest = 1'b0;
    end else begin
      if (!in_req) begin
        in_req = 1;
        wcnt   = $urandom_range(wait_hi, wait_lo);
      end
      if (wcnt > 0) begin
        master_waitrequest = 1'b1;
        wcnt--;
        extra++;
      end else begin
        master_waitrequest = 1'b0;
        in_req  = 0;
        pending = 1;
        lcnt    = $urandom_range(lat_hi, lat_lo);
        pdata   = mem[master_address[11:2]];
        addr_q.push_back(master_address);
        reads++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: exact 64-bit products, floor(p / 2^16) per term, sum taken
  // modulo 2^32 at the end, then bias and ReLU.
  function automatic logic [31:0] ref_dot(input int n, input logic [31:0] wb,
                                          input logic [31:0] ab, input logic [31:0] bias,
                                          input bit relu);
    longint sum, p;
    logic [31:0] r;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      p = longint'($signed(mem[wb[11:2] + i])) * longint'($signed(mem[ab[11:2] + i]));
      sum += p >>> 16;
    end
    sum += longint'($signed(bias));
    r = sum[31:0];
    if (relu && r[31]) r = '0;
    return r;
  endfunction

  task automatic set_stall(input int wl, input int wh, input int ll, input int lh);
    wait_lo = wl; wait_hi = wh; lat_lo = ll; lat_hi = lh;
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d, output int waits);
    slave_address = a; slave_writedata = d; slave_write = 1'b1; waits = 0;
    @(negedge clk);
    while (slave_waitrequest && waits < 2000) begin
      waits++;
      @(negedge clk);
    end
    if (slave_waitrequest) begin
      checks++; failures++;
      $display("FAIL write_timeout: offset %0d still stalled after %0d cycles", a, waits);
    end
    @(posedge clk); #1;
    slave_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [31:0] d, output int waits);
    slave_address = a; slave_read = 1'b1; waits = 0;
    @(negedge clk);
    while (slave_waitrequest && waits < 2000) begin
      waits++;
      @(negedge clk);
    end
    if (slave_waitrequest) begin
      checks++; failures++;
      $display("FAIL read_timeout: offset %0d still stalled after %0d cycles", a, waits);
    end
    d = slave_readdata;
    @(posedge clk); #1;
    slave_read = 1'b0;
  endtask

  task automatic program_job(input int n, input logic [31:0] bias, input bit relu);
    int dw;
    cpu_write(REG_WADDR, WB, dw);
    cpu_write(REG_AADDR, AB, dw);
    cpu_write(REG_LEN, 32'(n), dw);
    cpu_write(REG_BIAS, bias, dw);
    cpu_write(REG_RELU, {31'd0, relu}, dw);
  endtask

  task automatic run_job(input int n, input logic [31:0] bias, input bit relu,
                         output logic [31:0] res, output int waits);
    int dw;
    program_job(n, bias, relu);
    extra = 0; reads = 0; addr_q.delete();
    cpu_write(REG_START, $urandom(), dw);
    cpu_read(REG_START, res, waits);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #1;
    if (slave_waitrequest !== 1'b0) begin
      failures++; $display("FAIL reset_swait: got %0b want 0", slave_waitrequest);
    end
    checks++;
    if (master_read !== 1'b0) begin
      failures++; $display("FAIL reset_mread: got %0b want 0", master_read);
    end
    checks++;
    if (master_address !== '0) begin
      failures++; $display("FAIL reset_maddr: got %h want 0", master_address);
    end
    checks++;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      int w;
      cpu_read(4'(i), d, w);
      checks++;
      if (d !== 32'h0) begin
        failures++; $display("FAIL reset_reg%0d: got %h want 00000000", i, d);
      end
    end
  endtask

  task automatic test_readback();
    logic [31:0] vals [16];
    logic [31:0] exp, d;
    int w;
    for (int i = 1; i < 16; i++) begin
      vals[i] = $urandom();
      cpu_write(4'(i), vals[i], w);
    end
    for (int i = 1; i < 16; i++) begin
      case (i)
        1, 2, 3, 5: exp = vals[i];
        7:          exp = {31'd0, vals[i][0]};
        default:    exp = 32'h0;
      endcase
      cpu_read(4'(i), d, w);
      checks++;
      if (d !== exp) begin
        failures++; $display("FAIL readback_off%0d: got %h want %h", i, d, exp);
      end
    end
  endtask

  task automatic test_single();
    logic [31:0] res; int waits;
    set_stall(0, 0, 0, 0);
    mem[WB[11:2]] = 32'h0001_0000;
    mem[AB[11:2]] = 32'h0002_0000;
    run_job(1, 32'h0000_8000, 1'b0, res, waits);
    checks++;
    if (res !== 32'h0002_8000) begin
      failures++; $display("FAIL single_result: got %h want 00028000", res);
    end
    checks++;
    if (waits !== 6) begin
      failures++; $display("FAIL single_busy: got %0d cycles want 6", waits);
    end
    checks++;
    if (reads !== 2) begin
      failures++; $display("FAIL single_reads: got %0d want 2", reads);
    end
  endtask

  task automatic test_relu();
    logic [31:0] res; int waits;
    set_stall(0, 0, 0, 0);
    mem[WB[11:2]] = 32'hFFFF_0000;
    mem[AB[11:2]] = 32'h0003_0000;
    run_job(1, 32'h0, 1'b0, res, waits);
    checks++;
    if (res !== 32'hFFFD_0000) begin
      failures++; $display("FAIL relu_off: got %h want fffd0000", res);
    end
    run_job(1, 32'h0, 1'b1, res, waits);
    checks++;
    if (res !== 32'h0) begin
      failures++; $display("FAIL relu_on: got %h want 00000000", res);
    end
  endtask

  task automatic test_zero_len();
    logic [31:0] res; int waits;
    set_stall(0, 0, 0, 0);
    run_job(0, 32'h1234_5678, 1'b0, res, waits);
    checks++;
    if (res !== 32'h1234_5678) begin
      failures++; $display("FAIL zero_len_result: got %h want 12345678", res);
    end
    checks++;
    if (waits !== 1) begin
      failures++; $display("FAIL zero_len_busy: got %0d cycles want 1", waits);
    end
    checks++;
    if (reads !== 0) begin
      failures++; $display("FAIL zero_len_reads: got %0d want 0", reads);
    end
  endtask

  task automatic test_vec4();
    logic [31:0] res; int waits;
    for (int i = 0; i < 4; i++) begin
      mem[WB[11:2] + i] = 32'(i + 1) << 16;
      mem[AB[11:2] + i] = 32'h0000_8000;
    end
    set_stall(0, 0, 0, 0);
    run_job(4, 32'h0, 1'b0, res, waits);
    checks++;
    if (res !== 32'h0005_0000) begin
      failures++; $display("FAIL vec4_result: got %h want 00050000", res);
    end
    checks++;
    if (waits !== 21) begin
      failures++; $display("FAIL vec4_busy: got %0d cycles want 21", waits);
    end
    checks++;
    if (addr_q.size() !== 8) begin
      failures++; $display("FAIL vec4_naddr: got %0d want 8", addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (addr_q[2*i] !== WB + 32'(4*i) || addr_q[2*i+1] !== AB + 32'(4*i)) begin
          failures++;
          $display("FAIL vec4_addr%0d: got %h/%h want %h/%h", i, addr_q[2*i], addr_q[2*i+1],
                   WB + 32'(4*i), AB + 32'(4*i));
        end
      end
    end
    set_stall(0, 3, 0, 3);
    run_job(4, 32'h0, 1'b0, res, waits);
    checks++;
    if (res !== 32'h0005_0000) begin
      failures++; $display("FAIL vec4_stall_result: got %h want 00050000", res);
    end
    checks++;
    if (waits !== 21 + extra) begin
      failures++; $display("FAIL vec4_stall_busy: got %0d cycles want %0d", waits, 21 + extra);
    end
  endtask

  task automatic test_random();
    logic [31:0] res, exp, bias; int waits, n; bit relu;
    set_stall(0, 3, 0, 3);
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(8, 1);
      for (int i = 0; i < n; i++) begin
        mem[WB[11:2] + i] = (t < 3) ? $urandom() : 32'($signed(32'($urandom_range(16'hFFFF, 0)) - 32'h8000) <<< 4);
        mem[AB[11:2] + i] = $urandom();
      end
      bias = $urandom();
      relu = 1'($urandom_range(1, 0));
      exp  = ref_dot(n, WB, AB, bias, relu);
      run_job(n, bias, relu, res, waits);
      checks++;
      if (res !== exp) begin
        failures++; $display("FAIL random%0d_result: n=%0d got %h want %h", t, n, res, exp);
      end
      checks++;
      if (waits !== 5*n + 1 + extra) begin
        failures++; $display("FAIL random%0d_busy: got %0d want %0d", t, waits, 5*n + 1 + extra);
      end
    end
  endtask

  task automatic test_config_stall();
    logic [31:0] res, exp, d, new_bias; int w;
    set_stall(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      mem[WB[11:2] + i] = $urandom();
      mem[AB[11:2] + i] = $urandom();
    end
    program_job(3, 32'h0001_2345, 1'b0);
    exp = ref_dot(3, WB, AB, 32'h0001_2345, 1'b0);
    new_bias = 32'hCAFE_0001;
    cpu_write(REG_START, 32'h0, w);
    cpu_write(REG_BIAS, new_bias, w);
    checks++;
    if (w !== 16) begin
      failures++; $display("FAIL cfg_stall_cycles: got %0d want 16", w);
    end
    cpu_read(REG_START, res, w);
    checks++;
    if (res !== exp) begin
      failures++; $display("FAIL cfg_stall_result: got %h want %h", res, exp);
    end
    cpu_read(REG_BIAS, d, w);
    checks++;
    if (d !== new_bias) begin
      failures++; $display("FAIL cfg_stall_bias: got %h want %h", d, new_bias);
    end
    cpu_read(REG_WADDR, d, w);
    checks++;
    if (d !== WB) begin
      failures++; $display("FAIL cfg_keep_waddr: got %h want %h", d, WB);
    end
    cpu_read(REG_LEN, d, w);
    checks++;
    if (d !== 32'd3) begin
      failures++; $display("FAIL cfg_keep_len: got %h want 3", d);
    end
  endtask

  task automatic test_reset_midjob();
    logic [31:0] res, exp, d; int w; bit seen;
    set_stall(0, 0, 3, 3);
    for (int i = 0; i < 4; i++) begin
      mem[WB[11:2] + i] = $urandom();
      mem[AB[11:2] + i] = $urandom();
    end
    program_job(4, 32'h7777_0000, 1'b0);
    addr_q.delete();
    cpu_write(REG_START, 32'h0, w);
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (addr_q.size() >= 3) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen || master_address !== WB + 32'd4) begin
      failures++; $display("FAIL midjob_reach: seen=%0b addr %h want %h", seen, master_address, WB + 32'd4);
    end
    slave_address = REG_START; slave_read = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (slave_waitrequest !== 1'b0 || master_read !== 1'b0 || master_address !== '0 || slave_readdata !== '0) begin
      failures++;
      $display("FAIL midjob_reset_outputs: swait=%0b mread=%0b maddr=%h rdata=%h want all 0",
               slave_waitrequest, master_read, master_address, slave_readdata);
    end
    slave_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      cpu_read(4'(i), d, w);
      checks++;
      if (d !== 32'h0) begin
        failures++; $display("FAIL midjob_reg%0d: got %h want 00000000", i, d);
      end
    end
    set_stall(0, 3, 0, 3);
    exp = ref_dot(4, WB, AB, 32'h0000_1000, 1'b1);
    run_job(4, 32'h0000_1000, 1'b1, res, w);
    checks++;
    if (res !== exp) begin
      failures++; $display("FAIL midjob_new_job: got %h want %h", res, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    test_reset();
    test_readback();
    test_single();
    test_relu();
    test_zero_len();
    test_vec4();
    test_random();
    test_config_stall();
    test_reset_midjob();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
